// File: rtl/stream_fifo_pkg.sv
// Shared types and helpers for the stream FIFO.
package stream_fifo_pkg;

    // Read-side behaviour: registered read or first-word-fall-through.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Sticky error flags.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // True when n is a non-zero power of two.
    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for stream_fifo: one synchronous write port and
// one read port that is either combinational (FWFT head) or registered.
module fifo_ram #(
    parameter int WIDTH    = 9,
    parameter int DEPTH    = 128,
    parameter bit ASYNC_RD = 1'b0,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents are intentionally never reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    if (ASYNC_RD) begin : g_async_rd
        // Head entry is always visible; reset and read enable have no role here.
        logic unused_rd_ctrl;
        assign unused_rd_ctrl = i_rst ^ i_rd_en;
        assign o_rd_data      = mem[i_rd_addr];
    end else begin : g_sync_rd
        logic [WIDTH-1:0] rd_data_q;
        // Registered read; output holds its value between reads.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                rd_data_q <= '0;
            end else if (i_rd_en) begin
                rd_data_q <= mem[i_rd_addr];
            end
        end
        assign o_rd_data = rd_data_q;
    end

endmodule

// File: rtl/stream_fifo.sv
// Parametrised synchronous stream FIFO with registered or FWFT read,
// occupancy level, programmable almost flags, flush and sticky errors.
// Optional high-water-mark output o_hwm when STREAM_FIFO_HWM_EN is defined.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int         WIDTH = 9,
    parameter int         DEPTH = 128,
    parameter fifo_mode_e FWFT  = FIFO_STD,
    localparam int        AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid,
    input  logic             i_flush,
    input  logic             i_clr_err,
    input  logic [AW:0]      i_af_thresh,
    input  logic [AW:0]      i_ae_thresh,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic [AW:0]      o_level,
`ifdef STREAM_FIFO_HWM_EN
    output logic [AW:0]      o_hwm,
`endif
    output logic             o_overflow,
    output logic             o_underflow
);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("stream_fifo: DEPTH must be a power of two and at least 2");
    end

    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    fifo_err_t        err_q, err_d;
    logic             rd_ok, wr_ok;
    logic [WIDTH-1:0] ram_rd_data;

    // All flags come from the registered level.
    assign o_empty        = (level_q == '0);
    assign o_full         = (level_q == LVL_FULL);
    assign o_almost_full  = (level_q >= i_af_thresh);
    assign o_almost_empty = (level_q <= i_ae_thresh);
    assign o_level        = level_q;
    assign o_overflow     = err_q.overflow;
    assign o_underflow    = err_q.underflow;

    // Flush masks both requests, so nothing it swallows counts as an error.
    assign rd_ok = i_rd_en && !o_empty && !i_flush;
    assign wr_ok = i_wr_en && (!o_full || rd_ok) && !i_flush;

    // Pointer, level and sticky-error next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        err_d    = i_clr_err ? '0 : err_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   level_d = level_q + (AW + 1)'(1);
                2'b01:   level_d = level_q - (AW + 1)'(1);
                default: level_d = level_q;
            endcase
            if (i_wr_en && !wr_ok) err_d.overflow  = 1'b1;
            if (i_rd_en && !rd_ok) err_d.underflow = 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            err_q    <= err_d;
        end
    end

    fifo_ram #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ASYNC_RD (FWFT == FIFO_FWFT)
    ) u_ram (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (wr_ok),
        .i_wr_addr (wr_ptr_q),
        .i_wr_data (i_wr_data),
        .i_rd_en   (rd_ok),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (ram_rd_data)
    );

    assign o_rd_data = ram_rd_data;

    if (FWFT == FIFO_FWFT) begin : g_fwft
        assign o_rd_valid = !o_empty;
    end else begin : g_std
        logic rd_valid_q, rd_valid_d;
        // One-cycle pulse accompanying each registered read.
        always_comb begin
            rd_valid_d = rd_ok;
        end
        // Valid register.
        always_ff @(posedge i_clk) begin
            if (i_rst) rd_valid_q <= 1'b0;
            else       rd_valid_q <= rd_valid_d;
        end
        assign o_rd_valid = rd_valid_q;
    end

`ifdef STREAM_FIFO_HWM_EN
    logic [AW:0] hwm_q, hwm_d;
    // Track peak occupancy; error clear restarts it from the present level.
    always_comb begin
        hwm_d = hwm_q;
        if (i_clr_err)             hwm_d = level_q;
        else if (level_d > hwm_q)  hwm_d = level_d;
    end
    // High-water-mark register.
    always_ff @(posedge i_clk) begin
        if (i_rst) hwm_q <= '0;
        else       hwm_q <= hwm_d;
    end
    assign o_hwm = hwm_q;
`endif

endmodule
